alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit EX-stage ALU (add/sub/and/or + equality flag) between two requesters
//  (req0 = main EX issue, req1 = branch/auxiliary compare path) with valid/ready handshakes.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 27 ++
 rtl/alu_share_arbiter.sv | 115 +++++++++++
 tb/tb_alu_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, op-codes and the result-slot state encoding
// used by the EX-stage ALU and the arbiter that shares it.
package alu_pkg;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPW-1:0] ALU_SUB = 4'b0110;
    localparam logic [OPW-1:0] ALU_AND = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR  = 4'b0001;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slotState_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit EX-stage ALU: add/sub/and/or plus an operand
// equality flag that does not depend on the op-code.
module alu
    import alu_pkg::*;
(
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [OPW-1:0] op,
    output logic [DW-1:0]  res,
    output logic           flag
);

    // Unknown op-codes yield zero; sub wraps modulo 2^32 with no overflow flag.
    always_comb begin
        res = '0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a + (~b + 1'b1);
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = '0;
        endcase
    end

    assign flag = (a == b);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a single registered result slot giving 1-cycle latency.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DW       = 32,
    parameter int OPW      = 4,
    parameter int PRIO_RST = 0
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_res,
    output logic           rsp0_flag,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_res,
    output logic           rsp1_flag
);

    slotState_t     r_state;
    slotState_t     w_nextState;
    logic           r_owner;
    logic           r_prio;
    logic [DW-1:0]  r_res;
    logic           r_flag;

    logic           w_ownerRspReady;
    logic           w_slotFree;
    logic           w_grant;
    logic           w_grantIdx;
    logic [DW-1:0]  w_aluA;
    logic [DW-1:0]  w_aluB;
    logic [OPW-1:0] w_aluOp;
    logic [DW-1:0]  w_aluRes;
    logic           w_aluFlag;

    // A full slot frees up in the same cycle its owner consumes it, so a new
    // grant can refill it without a bubble.
    assign w_ownerRspReady = r_owner ? rsp1_ready : rsp0_ready;
    assign w_slotFree      = (r_state == ST_EMPTY) ||
                             ((r_state == ST_FULL) && w_ownerRspReady);
    assign w_grant         = w_slotFree && (req0_valid || req1_valid) && !rst;
    assign w_grantIdx      = (req0_valid && req1_valid) ? r_prio : req1_valid;

    assign w_aluA  = w_grantIdx ? req1_a  : req0_a;
    assign w_aluB  = w_grantIdx ? req1_b  : req0_b;
    assign w_aluOp = w_grantIdx ? req1_op : req0_op;

    alu u_alu (
        .a    (w_aluA),
        .b    (w_aluB),
        .op   (w_aluOp),
        .res  (w_aluRes),
        .flag (w_aluFlag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_grant) begin
            w_nextState = ST_FULL;
        end else if ((r_state == ST_FULL) && w_ownerRspReady) begin
            w_nextState = ST_EMPTY;
        end
    end

    always_comb begin
        req0_ready = w_grant && !w_grantIdx;
        req1_ready = w_grant &&  w_grantIdx;
        rsp0_valid = (r_state == ST_FULL) && !r_owner;
        rsp1_valid = (r_state == ST_FULL) &&  r_owner;
        rsp0_res   = r_res;
        rsp1_res   = r_res;
        rsp0_flag  = r_flag;
        rsp1_flag  = r_flag;
    end

    // Priority always passes to the requester that was not just served,
    // which gives strict alternation whenever both keep requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_prio  <= 1'(PRIO_RST);
            r_res   <= '0;
            r_flag  <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_grantIdx;
            r_prio  <= !w_grantIdx;
            r_res   <= w_aluRes;
            r_flag  <= w_aluFlag;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomised checks of the shared-ALU arbiter: reset, latency,
// round-robin grants, backpressure, op corners and a per-requester scoreboard.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        flag;
    } expRsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_flag;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_flag;
    logic [31:0] req0_a, req0_b, rsp0_res, req1_a, req1_b, rsp1_res;
    logic [3:0]  req0_op, req1_op;

    int errorCount = 0;
    int checkCount = 0;

    expRsp_t q0[$];
    expRsp_t q1[$];
    int      wait0 = 0;
    int      wait1 = 0;

    alu_share_arbiter #(.DW(32), .OPW(4), .PRIO_RST(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_res   (rsp0_res),
        .rsp0_flag  (rsp0_flag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_res   (rsp1_res),
        .rsp1_flag  (rsp1_flag)
    );

    always #5 clk = ~clk;

    // Independent reference for the expected ALU result of one operation.
    function automatic expRsp_t refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        expRsp_t e;
        case (op)
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            default: e.res = 32'd0;
        endcase
        e.flag = (a == b);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // One randomised cycle's bookkeeping, evaluated #1 after the negedge drive.
    task automatic observeCycle();
        expRsp_t e;
        if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) checkOutput("rand_rsp0_unexpected", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                checkOutput("rand_rsp0_res", rsp0_res, e.res);
                checkOutput("rand_rsp0_flag", {31'd0, rsp0_flag}, {31'd0, e.flag});
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) checkOutput("rand_rsp1_unexpected", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                checkOutput("rand_rsp1_res", rsp1_res, e.res);
                checkOutput("rand_rsp1_flag", {31'd0, rsp1_flag}, {31'd0, e.flag});
            end
        end
        checkOutput("rand_both_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
        checkOutput("rand_both_rspvalid", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
        if (req0_valid && req0_ready) q0.push_back(refAlu(req0_op, req0_a, req0_b));
        if (req1_valid && req1_ready) q1.push_back(refAlu(req1_op, req1_a, req1_b));
        if (!req0_valid || req0_ready) wait0 = 0;
        else if (req1_ready) begin
            wait0++;
            checkOutput("rand_starve0", {31'd0, wait0 > 2}, 32'd0);
        end
        if (!req1_valid || req1_ready) wait1 = 0;
        else if (req0_ready) begin
            wait1++;
            checkOutput("rand_starve1", {31'd0, wait1 > 2}, 32'd0);
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] opTable [5];
        opTable[0] = 4'b0010; opTable[1] = 4'b0110; opTable[2] = 4'b0000;
        opTable[3] = 4'b0001; opTable[4] = 4'b1111;

        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        applyStimulus(1, 1'b1, ALU_ADD, 32'd3, 32'd4);

        // Reset state with both requesters asserting valid.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("rst_rsp0_res", rsp0_res, 32'd0);
        checkOutput("rst_rsp0_flag", {31'd0, rsp0_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);

        // Contention from reset priority 0: expect grants 0,1,0,1.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        applyStimulus(1, 1'b1, ALU_SUB, 32'd3, 32'd5);
        #1;
        checkOutput("cont1_ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("cont1_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        checkOutput("cont1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        checkOutput("cont1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("cont1_res", rsp0_res, 32'h0000_F000);
        applyStimulus(0, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        #1;
        checkOutput("cont2_ready1", {31'd0, req1_ready}, 32'd1);
        checkOutput("cont2_ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        checkOutput("cont2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        checkOutput("cont2_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("cont2_res", rsp1_res, 32'hFFFF_FFFE);
        applyStimulus(1, 1'b1, ALU_ADD, 32'd50, 32'd50);
        #1;
        checkOutput("cont3_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        checkOutput("cont3_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        checkOutput("cont3_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("cont3_res", rsp0_res, 32'h0000_00FF);
        #1;
        checkOutput("cont4_ready1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        checkOutput("cont4_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        checkOutput("cont4_res", rsp1_res, 32'd100);
        checkOutput("cont4_flag", {31'd0, rsp1_flag}, 32'd1);
        applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("cont_drained", {31'd0, rsp1_valid}, 32'd0);

        // Single add 7+5 with 1-cycle latency.
        applyStimulus(0, 1'b1, ALU_ADD, 32'd7, 32'd5);
        #1;
        checkOutput("add_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
        checkOutput("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        checkOutput("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("add_res", rsp0_res, 32'd12);
        checkOutput("add_flag", {31'd0, rsp0_flag}, 32'd0);

        // Backpressure: result held, no grants, then drain and refill same edge.
        @(negedge clk);
        applyStimulus(0, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        rsp0_ready = 1'b0;
        #1;
        checkOutput("bp_ready0", {31'd0, req0_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
            applyStimulus(1, 1'b1, ALU_ADD, 32'd1, 32'd1);
            #1;
            checkOutput("bp_hold_valid", {31'd0, rsp0_valid}, 32'd1);
            checkOutput("bp_hold_res", rsp0_res, 32'h0000_00FF);
            checkOutput("bp_hold_ready0", {31'd0, req0_ready}, 32'd0);
            checkOutput("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        checkOutput("bp_refill_ready1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        rsp0_ready = 1'b0;
        applyStimulus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
        checkOutput("bp_rsp0_gone", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        checkOutput("bp_rsp1_res", rsp1_res, 32'd2);
        checkOutput("bp_rsp1_flag", {31'd0, rsp1_flag}, 32'd1);
        @(negedge clk);
        checkOutput("bp_empty", {31'd0, rsp1_valid}, 32'd0);

        // Unknown op with equal operands, then add across the full range.
        rsp0_ready = 1'b1;
        applyStimulus(0, 1'b1, 4'b1111, 32'd9, 32'd9);
        #1;
        checkOutput("bad_op_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
        applyStimulus(1, 1'b1, ALU_ADD, 32'd0, 32'hFFFF_FFFF);
        #1;
        checkOutput("bad_op_res", rsp0_res, 32'd0);
        checkOutput("bad_op_flag", {31'd0, rsp0_flag}, 32'd1);
        checkOutput("wide_add_ready1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
        checkOutput("wide_add_valid", {31'd0, rsp1_valid}, 32'd1);
        checkOutput("wide_add_res", rsp1_res, 32'hFFFF_FFFF);
        checkOutput("wide_add_flag", {31'd0, rsp1_flag}, 32'd0);

        // Reset asserted while a result is held.
        @(negedge clk);
        rsp0_ready = 1'b0;
        applyStimulus(0, 1'b1, ALU_ADD, 32'd2, 32'd3);
        @(negedge clk);
        checkOutput("midrst_before_res", rsp0_res, 32'd5);
        checkOutput("midrst_before_valid", {31'd0, rsp0_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid0", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("midrst_valid1", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("midrst_res", rsp0_res, 32'd0);
        checkOutput("midrst_ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);

        // Randomised traffic against the per-requester scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            for (int r = 0; r < 2; r++) begin
                logic [31:0] ra, rb;
                ra = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
                rb = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
                applyStimulus(r, ($urandom_range(0, 9) < 6), opTable[$urandom_range(0, 4)], ra, rb);
            end
            #1;
            observeCycle();
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
            applyStimulus(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
            applyStimulus(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
            #1;
            observeCycle();
        end
        checkOutput("rand_q0_empty", q0.size(), 32'd0);
        checkOutput("rand_q1_empty", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
